// File: rtl/shift_rows_stage.sv
// rtl/shift_rows_stage.sv - AES ShiftRows stage with a one-entry valid/ready output register
// Defining SHIFT_ROWS_INV_EN adds the inverse port, which selects InvShiftRows per accepted block.
module shift_rows_stage (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [127:0] input_block,
   input  logic         in_valid,
   output logic         in_ready,
`ifdef SHIFT_ROWS_INV_EN
   input  logic         inverse,
`endif
   output logic [127:0] shifted_block,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [31:0]  row0, row1, row2, row3;
   logic [127:0] fwd_block;
   logic [127:0] next_block;
   logic         accept;

   assign row0 = input_block[127:96];
   assign row1 = input_block[95:64];
   assign row2 = input_block[63:32];
   assign row3 = input_block[31:0];

   // Byte 0 of a row is its most significant byte, so a left rotate moves low bytes up.
   assign fwd_block = {row0,
                       row1[23:0], row1[31:24],
                       row2[15:0], row2[31:16],
                       row3[7:0],  row3[31:8]};

`ifdef SHIFT_ROWS_INV_EN
   logic [127:0] inv_block;

   assign inv_block = {row0,
                       row1[7:0],  row1[31:8],
                       row2[15:0], row2[31:16],
                       row3[23:0], row3[31:24]};

   assign next_block = inverse ? inv_block : fwd_block;
`else
   assign next_block = fwd_block;
`endif

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         shifted_block <= 128'h0;
         out_valid     <= 1'b0;
      end else if (accept) begin
         shifted_block <= next_block;
         out_valid     <= 1'b1;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_rows_stage.sv
// tb/tb_shift_rows_stage.sv - scoreboard bench for shift_rows_stage
module tb_shift_rows_stage;

   logic         clk;
   logic         n_rst;
   logic [127:0] input_block;
   logic         in_valid;
   logic         in_ready;
   logic         inv;
   logic [127:0] shifted_block;
   logic         out_valid;
   logic         out_ready;

   int checks;
   int failures;
   logic [127:0] sb [$];
   logic [127:0] last_out;

   shift_rows_stage dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .input_block   (input_block),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
`ifdef SHIFT_ROWS_INV_EN
      .inverse       (inv),
`endif
      .shifted_block (shifted_block),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] model(input logic [127:0] blk, input logic inv_sel);
      logic [7:0]   b [4][4];
      logic [127:0] o;
      int           src;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r][c] = blk[127 - 32*r - 8*c -: 8];
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src = inv_sel ? (c - r + 4) % 4 : (c + r) % 4;
            o[127 - 32*r - 8*c -: 8] = b[r][src];
         end
      return o;
   endfunction

   // One clock: drive inputs, judge accept/consume just before the edge, then advance.
   task automatic step(input logic v, input logic [127:0] d, input logic ordy);
      logic [127:0] exp_blk;
      in_valid    = v;
      input_block = d;
      out_ready   = ordy;
      #1;
      if (n_rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL consume_underflow: got %h, required no output", shifted_block);
         end else begin
            exp_blk = sb.pop_front();
            last_out = exp_blk;
            if (shifted_block !== exp_blk) begin
               failures++;
               $display("FAIL consume_data: got %h, required %h", shifted_block, exp_blk);
            end
         end
      end
      if (n_rst && in_valid && in_ready)
         sb.push_back(model(d, inv));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget;
      budget = 20;
      while (sb.size() != 0 && budget > 0) begin
         step(1'b0, '0, 1'b1);
         budget--;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      step(1'b1, 128'h1234, 1'b0);
      step(1'b0, '0, 1'b0);
      checks += 3;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b, required 0", out_valid);
      end
      if (shifted_block !== 128'h0) begin
         failures++; $display("FAIL reset_block: got %h, required 0", shifted_block);
      end
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b, required 1", in_ready);
      end
      sb.delete();
      n_rst = 1'b1;
      step(1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL idle_valid: got %b, required 0", out_valid);
      end
   endtask

   task automatic test_vectors();
      step(1'b1, 128'hD55D4040_3780AFE4_ECBA28F0_2B30F897, 1'b0);
      checks += 2;
      if (out_valid !== 1'b1) begin
         failures++; $display("FAIL vec1_valid: got %b, required 1", out_valid);
      end
      if (shifted_block !== 128'hD55D4040_80AFE437_28F0ECBA_972B30F8) begin
         failures++;
         $display("FAIL vec1_block: got %h, required %h", shifted_block,
                  128'hD55D4040_80AFE437_28F0ECBA_972B30F8);
      end
      step(1'b1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1);
      checks++;
      if (shifted_block !== 128'h00010203_05060704_0A0B0809_0F0C0D0E) begin
         failures++;
         $display("FAIL vec2_block: got %h, required %h", shifted_block,
                  128'h00010203_05060704_0A0B0809_0F0C0D0E);
      end
      drain();
      // Consume without accept leaves the data register untouched.
      checks += 2;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL hold_valid: got %b, required 0", out_valid);
      end
      if (shifted_block !== last_out) begin
         failures++; $display("FAIL hold_block: got %h, required %h", shifted_block, last_out);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] held;
      step(1'b1, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1'b0);
      held = model(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid    = 1'b1;
         input_block = {4{$urandom()}};
         out_ready   = 1'b0;
         #1;
         checks += 3;
         if (in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_ready: got %b, required 0", in_ready);
         end
         if (out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_valid: got %b, required 1", out_valid);
         end
         if (shifted_block !== held) begin
            failures++; $display("FAIL stall_block: got %h, required %h", shifted_block, held);
         end
         step(1'b1, input_block, 1'b0);
      end
      step(1'b1, 128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b1);
      checks += 2;
      if (out_valid !== 1'b1) begin
         failures++; $display("FAIL release_valid: got %b, required 1", out_valid);
      end
      if (sb.size() != 1) begin
         failures++; $display("FAIL release_accept: got %0d pending, required 1", sb.size());
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, {$urandom(), $urandom(), $urandom(), 24'h0, 8'(i)}, 1'b1);
         checks++;
         if (out_valid !== 1'b1) begin
            failures++; $display("FAIL stream_valid[%0d]: got %b, required 1", i, out_valid);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_stall();
      step(1'b1, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 1'b0);
      step(1'b1, 128'h5, 1'b0);
      n_rst = 1'b0;
      step(1'b1, 128'h6, 1'b1);
      checks += 3;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL rststall_valid: got %b, required 0", out_valid);
      end
      if (shifted_block !== 128'h0) begin
         failures++; $display("FAIL rststall_block: got %h, required 0", shifted_block);
      end
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL rststall_ready: got %b, required 1", in_ready);
      end
      sb.delete();
      n_rst = 1'b1;
   endtask

`ifdef SHIFT_ROWS_INV_EN
   task automatic test_inverse();
      inv = 1'b1;
      step(1'b1, 128'h00010203_05060704_0A0B0809_0F0C0D0E, 1'b1);
      checks++;
      if (shifted_block !== 128'h00010203_04050607_08090A0B_0C0D0E0F) begin
         failures++;
         $display("FAIL inverse_block: got %h, required %h", shifted_block,
                  128'h00010203_04050607_08090A0B_0C0D0E0F);
      end
      for (int i = 0; i < 4; i++)
         step(1'b1, {4{$urandom()}}, 1'b1);
      drain();
      inv = 1'b0;
   endtask
`endif

   initial begin
      checks      = 0;
      failures    = 0;
      n_rst       = 1'b0;
      in_valid    = 1'b0;
      input_block = '0;
      out_ready   = 1'b0;
      inv         = 1'b0;
      last_out    = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_stall();
`ifdef SHIFT_ROWS_INV_EN
      test_inverse();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
